// File: rtl/mops_sdo_pkg.sv
// Shared types and CANopen SDO constants for the MOPS SDO responder.
package mops_sdo_pkg;

  typedef struct packed {
    logic [10:0] cob_id;
    logic        rtr;
    logic [63:0] data;
  } frame_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECODE,
    S_FETCH,
    S_BUILD,
    S_SEND
  } state_t;

  typedef enum logic [1:0] {
    RESP_UPLOAD,
    RESP_DOWNLOAD,
    RESP_ABORT
  } resp_kind_t;

  localparam logic [7:0] SDO_CMD_UPLOAD_REQ = 8'h40;
  localparam logic [7:0] SDO_CMD_UPLOAD_RSP = 8'h4B;
  localparam logic [7:0] SDO_CMD_DL_4B      = 8'h23;
  localparam logic [7:0] SDO_CMD_DL_2B      = 8'h2B;
  localparam logic [7:0] SDO_CMD_DL_1B      = 8'h2F;
  localparam logic [7:0] SDO_CMD_DL_RSP     = 8'h60;
  localparam logic [7:0] SDO_CMD_ABORT      = 8'h80;

  localparam logic [31:0] ABORT_BAD_CMD   = 32'h0504_0001;
  localparam logic [31:0] ABORT_READ_ONLY = 32'h0601_0002;
  localparam logic [31:0] ABORT_NO_OBJECT = 32'h0602_0000;
  localparam logic [31:0] ABORT_BAD_LEN   = 32'h0607_0010;
  localparam logic [31:0] ABORT_BAD_SUB   = 32'h0609_0011;
  localparam logic [31:0] ABORT_TIMEOUT   = 32'h0800_0000;

  localparam logic [15:0] IDX_ADC = 16'h2400;
  localparam logic [15:0] IDX_CFG = 16'h2200;

  localparam logic [10:0] COB_SDO_RX = 11'h600;
  localparam logic [10:0] COB_SDO_TX = 11'h580;

  // Any expedited/segmented download initiate command has 0x2 in the upper nibble.
  function automatic logic is_download(input logic [7:0] cmd);
    return cmd[7:4] == 4'h2;
  endfunction

endpackage

// File: rtl/mops_sdo_frame_builder.sv
// Combinational packing of an SDO server response frame; multi-byte fields go out LSB first.
module mops_sdo_frame_builder
  import mops_sdo_pkg::*;
(
  input  resp_kind_t  kind_i,
  input  logic [6:0]  node_id_i,
  input  logic [15:0] index_i,
  input  logic [7:0]  sub_i,
  input  logic [31:0] value_i,
  output frame_t      frame_o
);

  logic [7:0]  cmd;
  logic [31:0] payload;

  always_comb begin
    cmd     = SDO_CMD_ABORT;
    payload = value_i;
    case (kind_i)
      RESP_UPLOAD:   cmd = SDO_CMD_UPLOAD_RSP;
      RESP_DOWNLOAD: begin
        cmd     = SDO_CMD_DL_RSP;
        payload = '0;
      end
      default:       cmd = SDO_CMD_ABORT;
    endcase
  end

  assign frame_o.cob_id = COB_SDO_TX + {4'h0, node_id_i};
  assign frame_o.rtr    = 1'b0;
  assign frame_o.data   = {cmd, index_i[7:0], index_i[15:8], sub_i,
                           payload[7:0], payload[15:8], payload[23:16], payload[31:24]};

endmodule

// File: rtl/mops_sdo_responder.sv
// CANopen SDO server standing in for one MOPS node: ADC uploads plus a config register.
// Define MOPS_SDO_DOWNLOAD_EN to make the config register writable by expedited download.
module mops_sdo_responder
  import mops_sdo_pkg::*;
#(
  parameter int unsigned ADC_TIMEOUT = 255,
  parameter int unsigned N_ADC_CH    = 35,
  parameter logic [15:0] CFG_RST     = 16'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  node_id,
  input  logic [75:0] rx_frame,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [75:0] tx_frame,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        adc_req,
  output logic [5:0]  adc_ch,
  input  logic        adc_ack,
  input  logic [11:0] adc_data,
  output logic [15:0] cfg_reg,
  output logic [7:0]  abort_cnt
);

  localparam int unsigned TW = (ADC_TIMEOUT < 2) ? 1 : $clog2(ADC_TIMEOUT + 1);

  state_t      state_q, state_d;
  logic [6:0]  node_q, node_d;
  logic [7:0]  cmd_q, cmd_d;
  logic [15:0] index_q, index_d;
  logic [7:0]  sub_q, sub_d;
  resp_kind_t  kind_q, kind_d;
  logic [31:0] payload_q, payload_d;
  logic [TW-1:0] timer_q, timer_d;
  logic        rx_ready_q, rx_ready_d;
  logic        tx_valid_q, tx_valid_d;
  frame_t      tx_frame_q, tx_frame_d;
  logic        adc_req_q, adc_req_d;
  logic [5:0]  adc_ch_q, adc_ch_d;
  logic [15:0] cfg_q, cfg_d;
  logic [7:0]  abort_cnt_q, abort_cnt_d;

  frame_t rx_in;
  frame_t built;
  assign rx_in = rx_frame;

`ifdef MOPS_SDO_DOWNLOAD_EN
  logic [15:0] wdata_q, wdata_d;
  logic        unused_rx;
  assign unused_rx = ^rx_frame[15:0];
`else
  logic        unused_rx;
  assign unused_rx = ^rx_frame[31:0];
`endif

  mops_sdo_frame_builder u_builder (
    .kind_i    (kind_q),
    .node_id_i (node_q),
    .index_i   (index_q),
    .sub_i     (sub_q),
    .value_i   (payload_q),
    .frame_o   (built)
  );

  always_comb begin
    // NOTE: every _d defaults to its _q before the case so no path can infer a latch.
    state_d     = state_q;
    node_d      = node_q;
    cmd_d       = cmd_q;
    index_d     = index_q;
    sub_d       = sub_q;
    kind_d      = kind_q;
    payload_d   = payload_q;
    timer_d     = timer_q;
    tx_valid_d  = tx_valid_q;
    tx_frame_d  = tx_frame_q;
    adc_req_d   = 1'b0;
    adc_ch_d    = adc_ch_q;
    cfg_d       = cfg_q;
    abort_cnt_d = abort_cnt_q;
`ifdef MOPS_SDO_DOWNLOAD_EN
    wdata_d     = wdata_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (rx_valid && rx_ready_q && !rx_in.rtr &&
            rx_in.cob_id == (COB_SDO_RX + {4'h0, node_id})) begin
          node_d  = node_id;
          cmd_d   = rx_in.data[63:56];
          index_d = {rx_in.data[47:40], rx_in.data[55:48]};
          sub_d   = rx_in.data[39:32];
`ifdef MOPS_SDO_DOWNLOAD_EN
          wdata_d = {rx_in.data[23:16], rx_in.data[31:24]};
`endif
          state_d = S_DECODE;
        end
      end

      S_DECODE: begin
        state_d = S_BUILD;
        kind_d  = RESP_ABORT;
        if (index_q == IDX_ADC) begin
          if (cmd_q != SDO_CMD_UPLOAD_REQ) begin
            payload_d = ABORT_BAD_CMD;
          end else if (sub_q == 8'd0 || sub_q > 8'(N_ADC_CH)) begin
            payload_d = ABORT_BAD_SUB;
          end else begin
            state_d   = S_FETCH;
            adc_req_d = 1'b1;
            adc_ch_d  = sub_q[5:0];
            timer_d   = '0;
          end
        end else if (index_q == IDX_CFG) begin
          if (cmd_q == SDO_CMD_UPLOAD_REQ) begin
            if (sub_q != 8'd0) begin
              payload_d = ABORT_BAD_SUB;
            end else begin
              kind_d    = RESP_UPLOAD;
              payload_d = {16'h0, cfg_q};
            end
`ifdef MOPS_SDO_DOWNLOAD_EN
          end else if (cmd_q == SDO_CMD_DL_2B) begin
            if (sub_q != 8'd0) begin
              payload_d = ABORT_BAD_SUB;
            end else begin
              kind_d    = RESP_DOWNLOAD;
              payload_d = '0;
            end
          end else if (cmd_q == SDO_CMD_DL_4B || cmd_q == SDO_CMD_DL_1B) begin
            payload_d = ABORT_BAD_LEN;
`else
          end else if (is_download(cmd_q)) begin
            payload_d = ABORT_READ_ONLY;
`endif
          end else begin
            payload_d = ABORT_BAD_CMD;
          end
        end else begin
          payload_d = ABORT_NO_OBJECT;
        end
      end

      S_FETCH: begin
        // An ack wins over the timeout if both land in the same cycle.
        if (adc_ack) begin
          kind_d    = RESP_UPLOAD;
          payload_d = {20'h0, adc_data};
          state_d   = S_BUILD;
        end else if (timer_q == TW'(ADC_TIMEOUT)) begin
          kind_d    = RESP_ABORT;
          payload_d = ABORT_TIMEOUT;
          state_d   = S_BUILD;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end

      S_BUILD: begin
        tx_frame_d = built;
        tx_valid_d = 1'b1;
        state_d    = S_SEND;
        if (kind_q == RESP_ABORT && abort_cnt_q != 8'hFF) begin
          abort_cnt_d = abort_cnt_q + 8'd1;
        end
`ifdef MOPS_SDO_DOWNLOAD_EN
        if (kind_q == RESP_DOWNLOAD) begin
          cfg_d = wdata_q;
        end
`endif
      end

      S_SEND: begin
        if (tx_ready) begin
          tx_valid_d = 1'b0;
          state_d    = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Registered so it stays low while reset is asserted.
    rx_ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      node_q      <= '0;
      cmd_q       <= '0;
      index_q     <= '0;
      sub_q       <= '0;
      kind_q      <= RESP_ABORT;
      payload_q   <= '0;
      timer_q     <= '0;
      rx_ready_q  <= 1'b0;
      tx_valid_q  <= 1'b0;
      tx_frame_q  <= '0;
      adc_req_q   <= 1'b0;
      adc_ch_q    <= '0;
      cfg_q       <= CFG_RST;
      abort_cnt_q <= '0;
`ifdef MOPS_SDO_DOWNLOAD_EN
      wdata_q     <= '0;
`endif
    end else begin
      // NOTE: nonblocking assignments so every register samples the same pre-edge values.
      state_q     <= state_d;
      node_q      <= node_d;
      cmd_q       <= cmd_d;
      index_q     <= index_d;
      sub_q       <= sub_d;
      kind_q      <= kind_d;
      payload_q   <= payload_d;
      timer_q     <= timer_d;
      rx_ready_q  <= rx_ready_d;
      tx_valid_q  <= tx_valid_d;
      tx_frame_q  <= tx_frame_d;
      adc_req_q   <= adc_req_d;
      adc_ch_q    <= adc_ch_d;
      cfg_q       <= cfg_d;
      abort_cnt_q <= abort_cnt_d;
`ifdef MOPS_SDO_DOWNLOAD_EN
      wdata_q     <= wdata_d;
`endif
    end
  end

  assign rx_ready  = rx_ready_q;
  assign tx_valid  = tx_valid_q;
  assign tx_frame  = tx_frame_q;
  assign adc_req   = adc_req_q;
  assign adc_ch    = adc_ch_q;
  assign cfg_reg   = cfg_q;
  assign abort_cnt = abort_cnt_q;

endmodule

// File: tb/tb_mops_sdo_responder.sv
// Self-checking bench for mops_sdo_responder: vector table, scoreboard and multi-cycle corner cases.
`timescale 1ns/1ps
module tb_mops_sdo_responder;

  localparam int          ADC_TIMEOUT = 255;
  localparam int          N_ADC_CH    = 35;
  localparam logic [15:0] CFG_RST     = 16'h5A3C;

  logic        clk;
  logic        rst;
  logic [6:0]  node_id;
  logic [75:0] rx_frame;
  logic        rx_valid;
  logic        rx_ready;
  logic [75:0] tx_frame;
  logic        tx_valid;
  logic        tx_ready;
  logic        adc_req;
  logic [5:0]  adc_ch;
  logic        adc_ack;
  logic [11:0] adc_data;
  logic [15:0] cfg_reg;
  logic [7:0]  abort_cnt;

  mops_sdo_responder #(
    .ADC_TIMEOUT (ADC_TIMEOUT),
    .N_ADC_CH    (N_ADC_CH),
    .CFG_RST     (CFG_RST)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .node_id   (node_id),
    .rx_frame  (rx_frame),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .tx_frame  (tx_frame),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .adc_req   (adc_req),
    .adc_ch    (adc_ch),
    .adc_ack   (adc_ack),
    .adc_data  (adc_data),
    .cfg_reg   (cfg_reg),
    .abort_cnt (abort_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [75:0] act, input logic [75:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: expected response frames, popped on every tx handshake.
  logic [75:0] exp_q[$];
  logic [75:0] exp_f;
  int          n_adc_req = 0;

  always @(negedge clk) begin
    if (adc_req) n_adc_req++;
    if (!rst && tx_valid && tx_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_tx: got %0h expected no frame", tx_frame);
      end else begin
        exp_f = exp_q.pop_front();
        check("tx_frame", tx_frame, exp_f);
      end
    end
  end

  // ADC model: delay 0 acks combinationally with the request, >0 acks that many cycles later, <0 never.
  int          adc_delay = -1;
  logic [11:0] adc_val = '0;
  logic        adc_ack_late = 1'b0;
  logic [5:0]  exp_ch = '0;

  assign adc_ack  = (adc_delay == 0) ? adc_req : adc_ack_late;
  assign adc_data = adc_val;

  initial forever begin
    @(posedge clk);
    #1;
    if (adc_req) begin
      check("adc_ch", 76'(adc_ch), 76'(exp_ch));
      if (adc_delay > 0) begin
        repeat (adc_delay) @(posedge clk);
        #1 adc_ack_late = 1'b1;
        @(posedge clk);
        #1 adc_ack_late = 1'b0;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  task automatic wait_rx_ready();
    int k = 0;
    while (!rx_ready && k < 50) begin
      @(posedge clk);
      #1;
      k++;
    end
    if (!rx_ready) begin
      n_checks++;
      n_errors++;
      $display("FAIL rx_ready_wait: got 0 expected 1 within 50 cycles");
    end
  endtask

  task automatic send(input logic [10:0] cob, input logic rtr, input logic [7:0] cmd,
                      input logic [15:0] idx, input logic [7:0] sub, input logic [15:0] wd);
    wait_rx_ready();
    rx_frame = {cob, rtr, cmd, idx[7:0], idx[15:8], sub, wd[7:0], wd[15:8], 16'h0};
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  // Called one cycle after the accept cycle; lat is the cycle offset of tx_valid from accept.
  task automatic wait_tx(input int budget, output int lat);
    lat = 1;
    while (!tx_valid && lat < budget) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (!tx_valid) begin
      n_checks++;
      n_errors++;
      $display("FAIL tx_valid_wait: got 0 after %0d cycles expected 1", lat);
    end
  endtask

  typedef struct {
    logic [6:0]  node;
    logic [10:0] cob;
    logic        rtr;
    logic [7:0]  cmd;
    logic [15:0] idx;
    logic [7:0]  sub;
    logic [15:0] wd;
    int          adc_delay;
    logic [11:0] adc_val;
    bit          resp;
    int          lat;
    logic [10:0] exp_cob;
    logic [63:0] exp_data;
  } vec_t;

  vec_t vecs[$];
  int   exp_aborts = 0;
  int   lat;
  int   cnt;
  int   req0;
  logic [75:0] stall_exp;

  initial begin
    rst      = 1'b1;
    node_id  = 7'h02;
    rx_frame = '0;
    rx_valid = 1'b0;
    tx_ready = 1'b1;

    vecs.push_back('{7'h02, 11'h602, 1'b0, 8'h40, 16'h2400, 8'h03, 16'h0, 1, 12'hABC, 1'b1, 5, 11'h582, 64'h4B002403_BC0A0000});
    vecs.push_back('{7'h02, 11'h602, 1'b0, 8'h40, 16'h2400, 8'h01, 16'h0, 0, 12'h123, 1'b1, 4, 11'h582, 64'h4B002401_23010000});
    vecs.push_back('{7'h02, 11'h602, 1'b0, 8'h40, 16'h2400, 8'h23, 16'h0, 3, 12'hFFF, 1'b1, 7, 11'h582, 64'h4B002423_FF0F0000});
    vecs.push_back('{7'h02, 11'h602, 1'b0, 8'h40, 16'h2400, 8'h24, 16'h0, -1, 12'h0, 1'b1, 3, 11'h582, 64'h80002424_11000906});
    vecs.push_back('{7'h02, 11'h602, 1'b0, 8'h40, 16'h2400, 8'h00, 16'h0, -1, 12'h0, 1'b1, 3, 11'h582, 64'h80002400_11000906});
    vecs.push_back('{7'h02, 11'h602, 1'b0, 8'h40, 16'h1000, 8'h00, 16'h0, -1, 12'h0, 1'b1, 3, 11'h582, 64'h80001000_00000206});
    vecs.push_back('{7'h02, 11'h602, 1'b0, 8'hA0, 16'h2400, 8'h01, 16'h0, -1, 12'h0, 1'b1, 3, 11'h582, 64'h80002401_01000405});
    vecs.push_back('{7'h02, 11'h602, 1'b0, 8'h40, 16'h2200, 8'h01, 16'h0, -1, 12'h0, 1'b1, 3, 11'h582, 64'h80002201_11000906});
    vecs.push_back('{7'h7F, 11'h67F, 1'b0, 8'h40, 16'h2200, 8'h00, 16'h0, -1, 12'h0, 1'b1, 3, 11'h5FF, 64'h4B002200_3C5A0000});
    vecs.push_back('{7'h02, 11'h603, 1'b0, 8'h40, 16'h2400, 8'h03, 16'h0, -1, 12'h0, 1'b0, 0, 11'h0, 64'h0});
    vecs.push_back('{7'h02, 11'h602, 1'b1, 8'h40, 16'h2400, 8'h03, 16'h0, -1, 12'h0, 1'b0, 0, 11'h0, 64'h0});
`ifdef MOPS_SDO_DOWNLOAD_EN
    vecs.push_back('{7'h02, 11'h602, 1'b0, 8'h2B, 16'h2200, 8'h00, 16'h1234, -1, 12'h0, 1'b1, 3, 11'h582, 64'h60002200_00000000});
    vecs.push_back('{7'h02, 11'h602, 1'b0, 8'h23, 16'h2200, 8'h00, 16'h9999, -1, 12'h0, 1'b1, 3, 11'h582, 64'h80002200_10000706});
    vecs.push_back('{7'h02, 11'h602, 1'b0, 8'h40, 16'h2200, 8'h00, 16'h0, -1, 12'h0, 1'b1, 3, 11'h582, 64'h4B002200_34120000});
`else
    vecs.push_back('{7'h02, 11'h602, 1'b0, 8'h2B, 16'h2200, 8'h00, 16'h1234, -1, 12'h0, 1'b1, 3, 11'h582, 64'h80002200_02000106});
    vecs.push_back('{7'h02, 11'h602, 1'b0, 8'h23, 16'h2200, 8'h00, 16'h9999, -1, 12'h0, 1'b1, 3, 11'h582, 64'h80002200_02000106});
    vecs.push_back('{7'h02, 11'h602, 1'b0, 8'h40, 16'h2200, 8'h00, 16'h0, -1, 12'h0, 1'b1, 3, 11'h582, 64'h4B002200_3C5A0000});
`endif

    // Reset state while rst is still asserted.
    repeat (3) @(posedge clk);
    #1;
    check("rst_rx_ready", 76'(rx_ready), 76'(0));
    check("rst_tx_valid", 76'(tx_valid), 76'(0));
    check("rst_cfg_reg", 76'(cfg_reg), 76'(CFG_RST));
    check("rst_abort_cnt", 76'(abort_cnt), 76'(0));
    rst = 1'b0;

    foreach (vecs[i]) begin
      node_id   = vecs[i].node;
      adc_delay = vecs[i].adc_delay;
      adc_val   = vecs[i].adc_val;
      exp_ch    = vecs[i].sub[5:0];
      req0      = n_adc_req;
      if (vecs[i].resp) begin
        exp_q.push_back({vecs[i].exp_cob, 1'b0, vecs[i].exp_data});
        if (vecs[i].exp_data[63:56] == 8'h80) exp_aborts++;
      end
      send(vecs[i].cob, vecs[i].rtr, vecs[i].cmd, vecs[i].idx, vecs[i].sub, vecs[i].wd);
      if (vecs[i].resp) begin
        wait_tx(400, lat);
        check($sformatf("latency[%0d]", i), 76'(lat), 76'(vecs[i].lat));
        @(posedge clk);
        #1;
      end else begin
        cnt = 0;
        repeat (10) begin
          if (tx_valid) cnt++;
          @(posedge clk);
          #1;
        end
        check($sformatf("drop_no_tx[%0d]", i), 76'(cnt), 76'(0));
      end
      check($sformatf("adc_req_pulses[%0d]", i), 76'(n_adc_req - req0),
            76'((vecs[i].adc_delay >= 0) ? 1 : 0));
    end
    node_id = 7'h02;
`ifdef MOPS_SDO_DOWNLOAD_EN
    check("cfg_after_download", 76'(cfg_reg), 76'(16'h1234));
`else
    check("cfg_after_download", 76'(cfg_reg), 76'(CFG_RST));
`endif
    check("abort_cnt_table", 76'(abort_cnt), 76'(exp_aborts));

    // Wrong node: silent for 300 cycles.
    send(11'h603, 1'b0, 8'h40, 16'h2400, 8'h03, 16'h0);
    cnt = 0;
    repeat (300) begin
      if (tx_valid) cnt++;
      @(posedge clk);
      #1;
    end
    check("wrong_node_300", 76'(cnt), 76'(0));

    // ADC never answers in time; the late ack arrives while idle and must be ignored.
    adc_delay = 300;
    exp_ch    = 6'h03;
    exp_q.push_back({11'h582, 1'b0, 64'h80002403_00000008});
    exp_aborts++;
    send(11'h602, 1'b0, 8'h40, 16'h2400, 8'h03, 16'h0);
    wait_tx(400, lat);
    check("timeout_latency", 76'(lat), 76'(4 + ADC_TIMEOUT));
    cnt = 0;
    repeat (70) begin
      @(posedge clk);
      #1;
      if (tx_valid) cnt++;
    end
    check("late_ack_ignored", 76'(cnt), 76'(0));
    check("abort_cnt_timeout", 76'(abort_cnt), 76'(exp_aborts));
    adc_delay = -1;

    // Back-pressure: response held stable, no new frame accepted.
    tx_ready = 1'b0;
`ifdef MOPS_SDO_DOWNLOAD_EN
    stall_exp = {11'h582, 1'b0, 64'h4B002200_34120000};
`else
    stall_exp = {11'h582, 1'b0, 64'h4B002200_3C5A0000};
`endif
    exp_q.push_back(stall_exp);
    send(11'h602, 1'b0, 8'h40, 16'h2200, 8'h00, 16'h0);
    rx_valid = 1'b1;
    wait_tx(20, lat);
    cnt = 0;
    repeat (20) begin
      if (tx_frame !== stall_exp || !tx_valid || rx_ready) cnt++;
      @(posedge clk);
      #1;
    end
    check("stall_stable", 76'(cnt), 76'(0));
    rx_valid = 1'b0;
    tx_ready = 1'b1;
    @(posedge clk);
    #1;
    check("stall_release_tx_valid", 76'(tx_valid), 76'(0));

    // Asynchronous reset in the middle of an ADC fetch.
    exp_ch = 6'h03;
    send(11'h602, 1'b0, 8'h40, 16'h2400, 8'h03, 16'h0);
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_rx_ready", 76'(rx_ready), 76'(0));
    check("mid_rst_tx_valid", 76'(tx_valid), 76'(0));
    check("mid_rst_tx_frame", tx_frame, 76'(0));
    check("mid_rst_adc_req", 76'(adc_req), 76'(0));
    check("mid_rst_adc_ch", 76'(adc_ch), 76'(0));
    check("mid_rst_cfg_reg", 76'(cfg_reg), 76'(CFG_RST));
    check("mid_rst_abort_cnt", 76'(abort_cnt), 76'(0));
    @(posedge clk);
    #1 rst = 1'b0;

    // Recovery transaction after reset.
    adc_delay = 2;
    adc_val   = 12'h5A5;
    exp_ch    = 6'h05;
    exp_q.push_back({11'h582, 1'b0, 64'h4B002405_A5050000});
    send(11'h602, 1'b0, 8'h40, 16'h2400, 8'h05, 16'h0);
    wait_tx(50, lat);
    check("post_rst_latency", 76'(lat), 76'(6));
    @(posedge clk);
    #1;
    adc_delay = -1;

    // abort_cnt saturates at 8'hFF.
    for (int k = 0; k < 256; k++) begin
      exp_q.push_back({11'h582, 1'b0, 64'h80003000_00000206});
      send(11'h602, 1'b0, 8'h40, 16'h3000, 8'h00, 16'h0);
      wait_tx(20, lat);
      @(posedge clk);
      #1;
    end
    check("abort_cnt_saturate", 76'(abort_cnt), 76'(8'hFF));

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_empty", 76'(exp_q.size()), 76'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
